// File: rtl/sprite_renderer_if.sv
// Sprite geometry types and the game_logic -> renderer sprite interface.
// sprite_t carries one rectangle: {x_pos, y_pos, right, bottom}.
package sprite_pkg;

    localparam int X_POS_W = 10;
    localparam int Y_POS_W = 9;

    typedef struct packed {
        logic [X_POS_W-1:0] x_pos;
        logic [Y_POS_W-1:0] y_pos;
        logic [X_POS_W-1:0] right;
        logic [Y_POS_W-1:0] bottom;
    } sprite_t;

endpackage

interface sprite_if;
    import sprite_pkg::*;

    sprite_t sprite;

    modport producer (output sprite);
    modport consumer (input  sprite);

endinterface

// File: rtl/sprite_renderer.sv
// Sprite renderer: snapshots sprite rectangles at frame start and turns
// display coordinates into RGB through a fixed 2-stage pipeline.
// Ports: clk_i, rst_i (async, active-high), sprites_i[] (sprite_if consumer),
//   new_frame_i, x_i, y_i, visible_i, hsync_i, vsync_i in;
//   red_o, green_o, blue_o, visible_o, hsync_o, vsync_o out (2-cycle delay).
module sprite_renderer
    import sprite_pkg::*;
#(
    parameter int                 N_SPRITES  = 3,
    parameter int                 H_RES      = 640,
    parameter int                 V_RES      = 480,
    parameter int                 COLOR_W    = 4,
    parameter int                 BORDER_W   = 8,
    parameter logic               SYNC_IDLE  = 1'b1,
    parameter logic [3*COLOR_W-1:0] FG_RGB     = 12'hFFF,
    parameter logic [3*COLOR_W-1:0] BORDER_RGB = 12'h888,
    parameter logic [3*COLOR_W-1:0] NET_RGB    = 12'h444,
    parameter logic [3*COLOR_W-1:0] BG_RGB     = 12'h000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    sprite_if.consumer         sprites_i [N_SPRITES],
    input  logic               new_frame_i,
    input  logic [X_POS_W-1:0] x_i,
    input  logic [Y_POS_W-1:0] y_i,
    input  logic               visible_i,
    input  logic               hsync_i,
    input  logic               vsync_i,
    output logic [COLOR_W-1:0] red_o,
    output logic [COLOR_W-1:0] green_o,
    output logic [COLOR_W-1:0] blue_o,
    output logic               visible_o,
    output logic               hsync_o,
    output logic               vsync_o
);

    localparam int RGB_W = 3 * COLOR_W;

    localparam logic [X_POS_W-1:0] XB_LO = X_POS_W'(BORDER_W);
    localparam logic [X_POS_W-1:0] XB_HI = X_POS_W'(H_RES - BORDER_W);
    localparam logic [Y_POS_W-1:0] YB_LO = Y_POS_W'(BORDER_W);
    localparam logic [Y_POS_W-1:0] YB_HI = Y_POS_W'(V_RES - BORDER_W);
    localparam logic [X_POS_W-1:0] XN_A  = X_POS_W'(H_RES / 2 - 1);
    localparam logic [X_POS_W-1:0] XN_B  = X_POS_W'(H_RES / 2);

    // Shadow copy of the sprites; only refreshed on new_frame_i so that
    // game-logic updates in the middle of a frame cannot tear the image.
    sprite_t                shadow_q [N_SPRITES];
    logic [N_SPRITES-1:0]   hit;

    for (genvar k = 0; k < N_SPRITES; k++) begin : g_spr
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                shadow_q[k] <= '0;
            end else if (new_frame_i) begin
                shadow_q[k] <= sprites_i[k].sprite;
            end
        end

        // Empty rectangles (right<=x_pos or bottom<=y_pos) fall out of
        // the compares naturally; no wrap-around is considered.
        assign hit[k] = (x_i >= shadow_q[k].x_pos)
                     && (x_i <  shadow_q[k].right)
                     && (y_i >= shadow_q[k].y_pos)
                     && (y_i <  shadow_q[k].bottom);
    end

    logic border_c;
    logic net_c;

    assign border_c = (x_i < XB_LO) || (x_i >= XB_HI)
                   || (y_i < YB_LO) || (y_i >= YB_HI);

    // Two-pixel-wide centre line, dashed every 16 lines.
    assign net_c = ((x_i == XN_A) || (x_i == XN_B)) && !y_i[4];

    // Stage 1: classification flags plus delayed timing signals.
    logic hit_q;
    logic border_q;
    logic net_q;
    logic vis_q;
    logic hs_q;
    logic vs_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_q    <= 1'b0;
            border_q <= 1'b0;
            net_q    <= 1'b0;
            vis_q    <= 1'b0;
            hs_q     <= SYNC_IDLE;
            vs_q     <= SYNC_IDLE;
        end else begin
            hit_q    <= |hit;
            border_q <= border_c;
            net_q    <= net_c;
            vis_q    <= visible_i;
            hs_q     <= hsync_i;
            vs_q     <= vsync_i;
        end
    end

    // Stage 2: first-match colour select.
    logic [RGB_W-1:0] rgb_d;
    logic [RGB_W-1:0] rgb_q;

    always_comb begin
        rgb_d = BG_RGB;
        if (!vis_q) begin
            rgb_d = '0;
        end else if (hit_q) begin
            rgb_d = FG_RGB;
        end else if (border_q) begin
            rgb_d = BORDER_RGB;
        end else if (net_q) begin
            rgb_d = NET_RGB;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rgb_q     <= '0;
            visible_o <= 1'b0;
            hsync_o   <= SYNC_IDLE;
            vsync_o   <= SYNC_IDLE;
        end else begin
            rgb_q     <= rgb_d;
            visible_o <= vis_q;
            hsync_o   <= hs_q;
            vsync_o   <= vs_q;
        end
    end

    assign red_o   = rgb_q[3*COLOR_W-1:2*COLOR_W];
    assign green_o = rgb_q[2*COLOR_W-1:COLOR_W];
    assign blue_o  = rgb_q[COLOR_W-1:0];

endmodule
